// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-parser state encoding, default start-of-frame
// byte and baud timing constants used by both the receiver and the frame stage.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_OUTPUT
    } frame_state_t;

    localparam logic [7:0]  SOF_DEFAULT  = 8'hAA;
    localparam int unsigned CLKS_PER_BIT = 391;

    // Two 10-bit byte times of silence end a frame in progress.
    localparam int unsigned BYTE_TIMEOUT_DEFAULT = 2 * 10 * CLKS_PER_BIT;

    function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-in / stream-out bundle of the frame receiver: UART byte strobe on the
// input side, valid/ready payload stream and error pulses on the output side.
interface uart_frame_rx_if;

    logic       rx_valid;
    logic [7:0] rx_data;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [7:0] frame_len;

    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       overrun;

    modport slave (
        input  rx_valid, rx_data, out_ready,
        output out_data, out_valid, out_last, frame_len,
        output err_chk, err_len, err_timeout, overrun
    );

    modport master (
        output rx_valid, rx_data, out_ready,
        input  out_data, out_valid, out_last, frame_len,
        input  err_chk, err_len, err_timeout, overrun
    );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, combinational read.
module uart_frame_buf #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser behind the UART receiver: SOF, LEN, payload, XOR checksum.
// Good frames are replayed as a valid/ready byte stream; bad traffic is flagged.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SOF            = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = BYTE_TIMEOUT_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    uart_frame_rx_if.slave  bus
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    frame_state_t     r_state;
    logic [7:0]       r_len;
    logic [7:0]       r_chk;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [TMO_W-1:0] r_tmo;

    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_err_chk;
    logic             r_err_len;
    logic             r_err_tmo;
    logic             r_overrun;

    logic             w_buf_we;
    logic [IDX_W-1:0] w_buf_raddr;
    logic [7:0]       w_buf_rdata;
    logic [IDX_W-1:0] w_rd_next;
    logic             w_wr_is_last;
    logic             w_rd_next_is_last;
    logic             w_in_frame;
    logic             w_handshake;
    logic [7:0]       w_len_m1;

    always_comb begin
        w_len_m1          = r_len - 8'd1;
        w_rd_next         = r_rd_idx + IDX_W'(1);
        w_wr_is_last      = (8'(r_wr_idx) == w_len_m1);
        w_rd_next_is_last = (8'(w_rd_next) == w_len_m1);
        w_in_frame        = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
        w_handshake       = r_out_valid && bus.out_ready;
        w_buf_we          = (r_state == ST_PAYLOAD) && bus.rx_valid;
        // Output data is registered, so the read port looks one byte ahead;
        // in CHK it presents byte 0 for the first output cycle.
        w_buf_raddr       = (r_state == ST_OUTPUT) ? w_rd_next : '0;
    end

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_wr_idx),
        .i_wdata (bus.rx_data),
        .i_raddr (w_buf_raddr),
        .o_rdata (w_buf_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_chk       <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_tmo       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err_chk   <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_err_chk <= 1'b0;
            r_err_len <= 1'b0;
            r_err_tmo <= 1'b0;
            r_overrun <= 1'b0;

            // Inter-byte silence inside a frame; byte arrivals are handled below.
            if (w_in_frame && !bus.rx_valid) begin
                if (r_tmo == TMO_LAST) begin
                    r_err_tmo <= 1'b1;
                    r_tmo     <= '0;
                    r_state   <= ST_IDLE;
                end else begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (bus.rx_valid && (bus.rx_data == SOF)) begin
                        r_tmo   <= '0;
                        r_state <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (bus.rx_valid) begin
                        r_len <= bus.rx_data;
                        r_chk <= bus.rx_data;
                        r_tmo <= '0;
                        if (len_ok(bus.rx_data, MAX_LEN_B)) begin
                            r_wr_idx <= '0;
                            r_state  <= ST_PAYLOAD;
                        end else begin
                            r_err_len <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (bus.rx_valid) begin
                        r_chk <= r_chk ^ bus.rx_data;
                        r_tmo <= '0;
                        if (w_wr_is_last) begin
                            r_state <= ST_CHK;
                        end else begin
                            r_wr_idx <= r_wr_idx + IDX_W'(1);
                        end
                    end
                end

                ST_CHK: begin
                    if (bus.rx_valid) begin
                        r_tmo <= '0;
                        if (bus.rx_data == r_chk) begin
                            r_rd_idx    <= '0;
                            r_out_data  <= w_buf_rdata;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (r_len == 8'd1);
                            r_state     <= ST_OUTPUT;
                        end else begin
                            r_err_chk <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end

                ST_OUTPUT: begin
                    if (bus.rx_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_handshake) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_rd_idx   <= w_rd_next;
                            r_out_data <= w_buf_rdata;
                            r_out_last <= w_rd_next_is_last;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;
    assign bus.frame_len   = r_len;
    assign bus.err_chk     = r_err_chk;
    assign bus.err_len     = r_err_len;
    assign bus.err_timeout = r_err_tmo;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed frames plus randomized traffic,
// checked by a frame-level reference model through a scoreboard and monitor.
module tb_uart_frame_rx;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TC      = 7820;
    localparam logic [7:0]  SOFB    = 8'hAA;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } exp_byte_t;
    typedef enum int {EV_CHK = 0, EV_LEN = 1, EV_TMO = 2, EV_OVR = 3} ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_rx_if bus();

    uart_frame_rx #(
        .MAX_LEN        (MAX_LEN),
        .SOF            (SOFB),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_byte_t data_q[$];
    ev_t       ev_q[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        ready_mode = 0;   // 0 high, 1 random, 2 low, 3 toggle

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: a frame is accepted iff LEN is legal and the XOR of
    // LEN and payload matches the trailing byte; its payload then appears in order.
    task automatic expect_frame(input bytes_t q);
        int         len;
        logic [7:0] x;
        len = int'(q[1]);
        if (len == 0 || len > MAX_LEN) begin
            ev_q.push_back(EV_LEN);
        end else begin
            x = q[1];
            for (int i = 0; i < len; i++) x = x ^ q[2+i];
            if (x == q[2+len]) begin
                for (int i = 0; i < len; i++)
                    data_q.push_back('{data: q[2+i], last: (i == len - 1), len: q[1]});
            end else begin
                ev_q.push_back(EV_CHK);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic send_raw(input bytes_t q, input bit tight);
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0 && !tight) repeat ($urandom_range(0, 2)) tick();
            send_byte(q[i]);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (data_q.size() == 0 && ev_q.size() == 0 && !bus.out_valid) break;
            tick();
        end
        check("drain_pending", data_q.size() + ev_q.size() + int'(bus.out_valid), 0);
        data_q.delete();
        ev_q.delete();
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.out_valid, bus.out_last, bus.err_chk, bus.err_len,
                     bus.err_timeout, bus.overrun, bus.out_data, bus.frame_len}, 0);
    endtask

    function automatic bytes_t make_good(input int len);
        bytes_t     q;
        logic [7:0] x, b;
        q = {SOFB, 8'(len)};
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = ($urandom_range(0, 7) == 0) ? SOFB : 8'($urandom);
            q.push_back(b);
            x = x ^ b;
        end
        q.push_back(x);
        return q;
    endfunction

    // Ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = ~bus.out_ready;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and every pulse.
    initial begin
        exp_byte_t  e;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic       prev_last = 1'b0;
        logic [3:0] prev_p = '0;
        logic [3:0] p;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_p     = '0;
            end else begin
                p = {bus.overrun, bus.err_timeout, bus.err_len, bus.err_chk};
                if (prev_stall) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, prev_data);
                    check("stall_last", bus.out_last, prev_last);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (data_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected none at %0t", bus.out_data, $time);
                    end else begin
                        e = data_q.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_last", bus.out_last, e.last);
                        check("frame_len", bus.frame_len, e.len);
                    end
                end
                for (int k = 0; k < 4; k++) begin
                    if (p[k]) begin
                        check($sformatf("pulse_width_%0d", k), prev_p[k], 0);
                        if (ev_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_pulse: got kind %0d, expected none at %0t", k, $time);
                        end else begin
                            check("pulse_kind", k, int'(ev_q.pop_front()));
                        end
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
                prev_p     = p;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no finish, expected finish at %0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        bytes_t q;
        int     k;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset_outputs");

        // Good frame with exact output timing
        q = {8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        expect_frame(q);
        send_raw(q, 1'b0);
        check("latency_valid", bus.out_valid, 1);
        check("byte0", bus.out_data, 8'h11);
        tick();
        check("byte1", bus.out_data, 8'h22);
        tick();
        check("byte2_last", {bus.out_valid, bus.out_last, bus.out_data}, {2'b11, 8'h33});
        tick();
        check("end_valid", bus.out_valid, 0);
        wait_idle();

        // Bad checksum, then recovery
        q = {8'hAA, 8'h02, 8'h01, 8'h02, 8'h04};
        expect_frame(q);
        send_raw(q, 1'b0);
        wait_idle();
        q = {8'hAA, 8'h01, 8'h5A, 8'h5B};
        expect_frame(q);
        send_raw(q, 1'b1);
        wait_idle();

        // Bad lengths, then recovery
        q = {8'hAA, 8'h00};
        expect_frame(q);
        send_raw(q, 1'b1);
        wait_idle();
        q = {8'hAA, 8'h11};
        expect_frame(q);
        send_raw(q, 1'b0);
        wait_idle();
        q = {8'hAA, 8'h01, 8'h07, 8'h06};
        expect_frame(q);
        send_raw(q, 1'b0);
        wait_idle();

        // Inter-byte timeout
        ev_q.push_back(EV_TMO);
        q = {8'hAA, 8'h02, 8'h01};
        send_raw(q, 1'b0);
        k = 0;
        while (k < TC + 20) begin
            tick();
            k++;
            if (bus.err_timeout) break;
        end
        check("timeout_latency", k, TC);
        wait_idle();
        q = make_good(2);
        expect_frame(q);
        send_raw(q, 1'b0);
        wait_idle();

        // Backpressure and overrun
        ready_mode = 2;
        tick();
        tick();
        q = make_good(4);
        expect_frame(q);
        send_raw(q, 1'b0);
        tick();
        tick();
        ev_q.push_back(EV_OVR);
        send_byte(8'($urandom));
        tick();
        tick();
        ready_mode = 3;
        wait_idle();
        ready_mode = 0;
        tick();

        // Reset during PAYLOAD
        q = {8'hAA, 8'h05, 8'h01, 8'h02};
        send_raw(q, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_payload");
        tick();
        data_q.delete();
        ev_q.delete();
        rst_n = 1'b1;
        tick();

        // Reset during OUTPUT
        ready_mode = 2;
        tick();
        q = make_good(3);
        expect_frame(q);
        send_raw(q, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_output");
        tick();
        data_q.delete();
        ev_q.delete();
        rst_n = 1'b1;
        ready_mode = 0;
        tick();
        tick();
        q = make_good(5);
        expect_frame(q);
        send_raw(q, 1'b0);
        wait_idle();

        // Randomized traffic
        ready_mode = 1;
        for (int n = 0; n < 40; n++) begin
            int         kind;
            logic [7:0] g;
            kind = $urandom_range(0, 99);
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == SOFB) g = 8'h00;
                send_byte(g);
            end
            if (kind < 15) begin
                q = {SOFB, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255))};
            end else begin
                q = make_good($urandom_range(1, MAX_LEN));
                if (kind < 30) q[q.size()-1] = q[q.size()-1] ^ 8'($urandom_range(1, 255));
            end
            expect_frame(q);
            send_raw(q, ($urandom_range(0, 3) == 0));
            wait_idle();
        end

        check("leftover_events", data_q.size() + ev_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
